// File: rtl/uart_ocp_slave_pkg.sv
// Shared OCP command-bus constants used by the UART transaction bridge and its targets.
//   mcmd_e  : MCmd encodings (IDLE / WR / RD); other codes are illegal
//   sresp_e : SResp encodings (NULL / DVA / ERR)
//   IdAddr  : address of the read-only ID register
package uart_ocp_slave_pkg;

    typedef enum logic [2:0] {
        CmdIdle = 3'b000,
        CmdWr   = 3'b001,
        CmdRd   = 3'b010
    } mcmd_e;

    typedef enum logic [1:0] {
        RespNull = 2'b00,
        RespDva  = 2'b01,
        RespErr  = 2'b11
    } sresp_e;

    localparam logic [7:0] IdAddr = 8'hFF;

endpackage

// File: rtl/ocp_reg_bank.sv
// NUM_REGS x 8-bit register storage for the OCP slave.
//   clk, reset : clock and synchronous active-high clear
//   we         : write enable; wdata is stored at waddr on the rising edge
//   waddr      : write address (ignored if >= NUM_REGS)
//   wdata      : write data
//   raddr      : combinational read address
//   rdata      : read data (0 for addresses >= NUM_REGS)
//   regs_q     : flat contents, register n at bits [8n+7:8n]
module ocp_reg_bank #(
    parameter int unsigned NUM_REGS = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic [7:0]            waddr,
    input  logic [7:0]            wdata,
    input  logic [7:0]            raddr,
    output logic [7:0]            rdata,
    output logic [8*NUM_REGS-1:0] regs_q
);

    logic [NUM_REGS-1:0][7:0] mem_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_q <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (we && (waddr == 8'(i))) begin
                    mem_q[i] <= wdata;
                end
            end
        end
    end

    always_comb begin
        rdata = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (raddr == 8'(i)) begin
                rdata = mem_q[i];
            end
        end
    end

    assign regs_q = mem_q;

endmodule

// File: rtl/uart_ocp_slave.sv
// OCP-style target: decodes IDLE/WR/RD, inserts WAIT_CYCLES wait states, then accepts
// for one cycle and responds for one cycle. Holds NUM_REGS RW registers and an ID register.
//   clk, reset  : clock and synchronous active-high reset
//   MCmd/MAddr/MData : command, address and write data from the master
//   SCmdAccept  : one-cycle accept pulse
//   SData/SResp : read data and response code, valid for one cycle
//   busy        : high while not IDLE
//   regs_q      : flat register contents
//   wr_stb/wr_addr : committed-write pulse and its address, in the response cycle
module uart_ocp_slave
    import uart_ocp_slave_pkg::*;
#(
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter logic [7:0]  ID_VALUE    = 8'hA5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [2:0]            MCmd,
    input  logic [7:0]            MAddr,
    input  logic [7:0]            MData,
    output logic                  SCmdAccept,
    output logic [7:0]            SData,
    output logic [1:0]            SResp,
    output logic                  busy,
    output logic [8*NUM_REGS-1:0] regs_q,
    output logic                  wr_stb,
    output logic [7:0]            wr_addr
);

    typedef enum logic [1:0] {StIdle, StWait, StAccept, StResp} state_e;

    localparam logic [8:0] NumRegs9 = 9'(NUM_REGS);
    localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

    state_e     state_q;
    logic [3:0] cnt_q;
    logic [2:0] cmd_q;
    logic [7:0] addr_q;
    logic [7:0] data_q;

    logic       in_range;
    logic       is_id;
    logic       wr_ok;
    logic       rd_ok;
    logic       bank_we;
    logic [7:0] bank_rdata;
    logic [7:0] rd_val;

    // Decode works entirely from the latched command; live inputs are ignored once busy.
    assign in_range = ({1'b0, addr_q} < NumRegs9);
    assign is_id    = (addr_q == IdAddr);
    assign wr_ok    = (cmd_q == CmdWr) && in_range;
    assign rd_ok    = (cmd_q == CmdRd) && (in_range || is_id);
    assign rd_val   = is_id ? ID_VALUE : bank_rdata;
    // Write lands at the end of ACCEPT so regs_q shows it together with wr_stb.
    assign bank_we  = (state_q == StAccept) && wr_ok;

    ocp_reg_bank #(
        .NUM_REGS(NUM_REGS)
    ) u_reg_bank (
        .clk   (clk),
        .reset (reset),
        .we    (bank_we),
        .waddr (addr_q),
        .wdata (data_q),
        .raddr (addr_q),
        .rdata (bank_rdata),
        .regs_q(regs_q)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= 4'd0;
            cmd_q      <= 3'd0;
            addr_q     <= 8'd0;
            data_q     <= 8'd0;
            SCmdAccept <= 1'b0;
            SData      <= 8'd0;
            SResp      <= RespNull;
            busy       <= 1'b0;
            wr_stb     <= 1'b0;
            wr_addr    <= 8'd0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (MCmd != CmdIdle) begin
                        cmd_q   <= MCmd;
                        addr_q  <= MAddr;
                        data_q  <= MData;
                        cnt_q   <= WaitInit;
                        busy    <= 1'b1;
                        state_q <= StWait;
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        SCmdAccept <= 1'b1;
                        state_q    <= StAccept;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StAccept: begin
                    SCmdAccept <= 1'b0;
                    state_q    <= StResp;
                    if (wr_ok) begin
                        SResp   <= RespDva;
                        SData   <= 8'd0;
                        wr_stb  <= 1'b1;
                        wr_addr <= addr_q;
                    end else if (rd_ok) begin
                        SResp <= RespDva;
                        SData <= rd_val;
                    end else begin
                        SResp <= RespErr;
                        SData <= 8'd0;
                    end
                end
                StResp: begin
                    SResp   <= RespNull;
                    SData   <= 8'd0;
                    wr_stb  <= 1'b0;
                    busy    <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_ocp_slave.sv
// Scoreboard bench: two slaves (WAIT_CYCLES=1 and 0); expected responses are queued
// at issue time and popped by per-DUT monitors whenever SResp is non-NULL.
module tb_uart_ocp_slave;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]   mcmd_a = '0, mcmd_b = '0;
    logic [7:0]   maddr_a = '0, maddr_b = '0, mdata_a = '0, mdata_b = '0;
    logic         acc_a, acc_b, busy_a, busy_b, stb_a, stb_b;
    logic [7:0]   sdata_a, sdata_b, waddr_a, waddr_b;
    logic [1:0]   sresp_a, sresp_b;
    logic [127:0] regs_a, regs_b;

    uart_ocp_slave #(.NUM_REGS(16), .WAIT_CYCLES(1), .ID_VALUE(8'hA5)) dut_a (
        .clk(clk), .reset(reset), .MCmd(mcmd_a), .MAddr(maddr_a), .MData(mdata_a),
        .SCmdAccept(acc_a), .SData(sdata_a), .SResp(sresp_a), .busy(busy_a),
        .regs_q(regs_a), .wr_stb(stb_a), .wr_addr(waddr_a)
    );

    uart_ocp_slave #(.NUM_REGS(16), .WAIT_CYCLES(0), .ID_VALUE(8'hA5)) dut_b (
        .clk(clk), .reset(reset), .MCmd(mcmd_b), .MAddr(maddr_b), .MData(mdata_b),
        .SCmdAccept(acc_b), .SData(sdata_b), .SResp(sresp_b), .busy(busy_b),
        .regs_q(regs_b), .wr_stb(stb_b), .wr_addr(waddr_b)
    );

    typedef struct packed {
        logic [1:0]   resp;
        logic [7:0]   data;
        logic         stb;
        logic [7:0]   addr;
        logic [127:0] regs;
    } exp_t;

    exp_t       q_a[$];
    exp_t       q_b[$];
    logic [7:0] model_a[16];
    logic [7:0] model_b[16];
    int         n_vec  = 0;
    int         n_fail = 0;
    bit         mon_en = 1'b0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] pack_model(input int sel);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = (sel == 0) ? model_a[i] : model_b[i];
        return r;
    endfunction

    task automatic mon_check(input int sel, input logic [1:0] resp, input logic [7:0] data,
                             input logic stb, input logic [7:0] addr, input logic [127:0] regs);
        exp_t e;
        string tag;
        tag = (sel == 0) ? "a" : "b";
        if ((sel == 0) ? (q_a.size() == 0) : (q_b.size() == 0)) begin
            n_vec++;
            n_fail++;
            $display("FAIL %s_unexpected_resp: got resp %0h with nothing expected", tag, resp);
            return;
        end
        e = (sel == 0) ? q_a.pop_front() : q_b.pop_front();
        chk({tag, "_sresp"}, 128'(resp), 128'(e.resp));
        chk({tag, "_sdata"}, 128'(data), 128'(e.data));
        chk({tag, "_wr_stb"}, 128'(stb), 128'(e.stb));
        if (e.stb) chk({tag, "_wr_addr"}, 128'(addr), 128'(e.addr));
        chk({tag, "_regs_q"}, regs, e.regs);
    endtask

    always @(negedge clk)
        if (mon_en && sresp_a != 2'b00) mon_check(0, sresp_a, sdata_a, stb_a, waddr_a, regs_a);
    always @(negedge clk)
        if (mon_en && sresp_b != 2'b00) mon_check(1, sresp_b, sdata_b, stb_b, waddr_b, regs_b);

    // Called just after a rising edge while the target is IDLE; returns at the start of
    // the first IDLE cycle after the response. hold keeps the command up through RESP.
    task automatic issue(input int sel, input logic [2:0] cmd, input logic [7:0] addr,
                         input logic [7:0] data, input logic [1:0] eresp,
                         input logic [7:0] edata, input logic estb, input int eacc,
                         input bit hold);
        exp_t e;
        int   n;
        if (sel == 0) begin
            mcmd_a = cmd; maddr_a = addr; mdata_a = data;
            if (estb) model_a[addr[3:0]] = data;
        end else begin
            mcmd_b = cmd; maddr_b = addr; mdata_b = data;
            if (estb) model_b[addr[3:0]] = data;
        end
        e.resp = eresp; e.data = edata; e.stb = estb; e.addr = addr;
        e.regs = pack_model(sel);
        if (sel == 0) q_a.push_back(e); else q_b.push_back(e);
        n = 0;
        @(negedge clk);
        while (((sel == 0) ? acc_a : acc_b) !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk((sel == 0) ? "a_accept_cycle" : "b_accept_cycle", 128'(n), 128'(eacc));
        @(posedge clk); #1;
        if (!hold) begin
            if (sel == 0) mcmd_a = 3'b000; else mcmd_b = 3'b000;
        end
        @(posedge clk); #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            model_a[i] = 8'h00;
            model_b[i] = 8'h00;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_accept", 128'(acc_a), 128'(0));
        chk("rst_sresp", 128'(sresp_a), 128'(0));
        chk("rst_sdata", 128'(sdata_a), 128'(0));
        chk("rst_busy", 128'(busy_a), 128'(0));
        chk("rst_wr_stb", 128'(stb_a), 128'(0));
        chk("rst_wr_addr", 128'(waddr_a), 128'(0));
        chk("rst_regs", regs_a, 128'(0));
        chk("rst_b_busy", 128'(busy_b), 128'(0));
        @(posedge clk); #1;
        reset = 1'b0;
        mon_en = 1'b1;

        // WAIT_CYCLES=1: accept in cycle 3, response in cycle 4
        issue(0, 3'b001, 8'h02, 8'h3C, 2'b01, 8'h00, 1'b1, 3, 1'b0);
        issue(0, 3'b010, 8'h02, 8'h00, 2'b01, 8'h3C, 1'b0, 3, 1'b0);
        issue(0, 3'b010, 8'hFF, 8'h00, 2'b01, 8'hA5, 1'b0, 3, 1'b0);
        issue(0, 3'b001, 8'h20, 8'h55, 2'b11, 8'h00, 1'b0, 3, 1'b0);
        issue(0, 3'b001, 8'hFF, 8'h11, 2'b11, 8'h00, 1'b0, 3, 1'b0);
        issue(0, 3'b101, 8'h02, 8'h99, 2'b11, 8'h00, 1'b0, 3, 1'b0);
        issue(0, 3'b001, 8'h0F, 8'h81, 2'b01, 8'h00, 1'b1, 3, 1'b0);
        issue(0, 3'b010, 8'h10, 8'h00, 2'b11, 8'h00, 1'b0, 3, 1'b0);
        issue(0, 3'b010, 8'h0F, 8'h00, 2'b01, 8'h81, 1'b0, 3, 1'b0);
        issue(0, 3'b011, 8'h01, 8'h00, 2'b11, 8'h00, 1'b0, 3, 1'b0);

        // Reset during WAIT drops the command; held command restarts after release
        mcmd_a = 3'b001; maddr_a = 8'h03; mdata_a = 8'h77;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rstw_busy", 128'(busy_a), 128'(0));
        chk("rstw_accept", 128'(acc_a), 128'(0));
        chk("rstw_sresp", 128'(sresp_a), 128'(0));
        chk("rstw_regs", regs_a, 128'(0));
        for (int i = 0; i < 16; i++) begin
            model_a[i] = 8'h00;
            model_b[i] = 8'h00;
        end
        @(posedge clk); #1;
        reset = 1'b0;
        issue(0, 3'b001, 8'h03, 8'h77, 2'b01, 8'h00, 1'b1, 3, 1'b0);
        issue(0, 3'b010, 8'h02, 8'h00, 2'b01, 8'h00, 1'b0, 3, 1'b0);
        issue(0, 3'b010, 8'h03, 8'h00, 2'b01, 8'h77, 1'b0, 3, 1'b0);

        // WAIT_CYCLES=0, back-to-back with command held one cycle past accept
        issue(1, 3'b001, 8'h05, 8'hC3, 2'b01, 8'h00, 1'b1, 2, 1'b1);
        issue(1, 3'b010, 8'h05, 8'h00, 2'b01, 8'hC3, 1'b0, 2, 1'b1);
        issue(1, 3'b001, 8'h00, 8'h5A, 2'b01, 8'h00, 1'b1, 2, 1'b1);
        issue(1, 3'b010, 8'h00, 8'h00, 2'b01, 8'h5A, 1'b0, 2, 1'b0);

        repeat (6) @(posedge clk);
        @(negedge clk);
        chk("a_queue_drained", 128'(q_a.size()), 128'(0));
        chk("b_queue_drained", 128'(q_b.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
